// File: rtl/opb_register_simulink2ppc_pkg.sv
// Shared definitions for the fabric-to-processor software register:
// register offsets, STATUS/CTRL bit positions and small decode helpers.
package opb_register_simulink2ppc_pkg;

  localparam logic [31:0] OFF_DATA   = 32'h0000_0000;
  localparam logic [31:0] OFF_STATUS = 32'h0000_0004;
  localparam logic [31:0] OFF_CTRL   = 32'h0000_0008;

  localparam int STAT_NEW     = 0;
  localparam int STAT_OVR     = 1;
  localparam int STAT_CNT_LSB = 16;

  localparam int CTRL_FREEZE = 0;
  localparam int CTRL_CLR    = 1;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    REG_DATA,
    REG_STATUS,
    REG_CTRL,
    REG_NONE
  } reg_sel_e;

  // Byte offset within the window -> register; anything past CTRL reads as zero.
  function automatic reg_sel_e decode_offset(input logic [31:0] off);
    reg_sel_e sel;
    case (off & ~32'h3)
      OFF_DATA:   sel = REG_DATA;
      OFF_STATUS: sel = REG_STATUS;
      OFF_CTRL:   sel = REG_CTRL;
      default:    sel = REG_NONE;
    endcase
    return sel;
  endfunction

  function automatic logic [31:0] status_word(input logic            new_flag,
                                              input logic            ovr_flag,
                                              input logic [CNT_W-1:0] cnt);
    logic [31:0] w;
    w = '0;
    w[STAT_NEW] = new_flag;
    w[STAT_OVR] = ovr_flag;
    w[STAT_CNT_LSB +: CNT_W] = cnt;
    return w;
  endfunction

endpackage

// File: rtl/opb_register_simulink2ppc_if.sv
// OPB master/slave signal bundle; vectors keep the bus's bit-0-is-MSB numbering.
interface opb_register_simulink2ppc_if;

  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;

  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );

endinterface

// File: rtl/opb_register_simulink2ppc_opb_slave_decode.sv
// OPB slave front end: window compare, register select, and a one-cycle ack
// that re-arms only after select has been seen low.
module opb_slave_decode
  import opb_register_simulink2ppc_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0100_0300,
  parameter logic [31:0] C_HIGHADDR   = 32'h0100_03FF,
  parameter int          C_OPB_AWIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  select_i,
  input  logic [0:C_OPB_AWIDTH-1] abus_i,
  input  logic                  rnw_i,
  input  logic                  be3_i,
  input  logic [1:0]            wbits_i,
  output logic                  xfer_o,
  output reg_sel_e              sel_o,
  output logic                  rnw_o,
  output logic                  be3_o,
  output logic [1:0]            wbits_o,
  output logic                  ack_o
);

  logic       in_window;
  logic       hit;
  logic [C_OPB_AWIDTH-1:0] off;
  logic       armed_q, armed_d;
  logic       xfer_q;
  logic       ack_q;
  reg_sel_e   sel_q;
  logic       rnw_q;
  logic       be3_q;
  logic [1:0] wbits_q;

  assign in_window = (abus_i >= C_BASEADDR) && (abus_i <= C_HIGHADDR);
  assign off       = abus_i - C_BASEADDR;
  assign hit       = select_i && armed_q && in_window;

  // A held select must not re-trigger; one low sample re-arms.
  always_comb begin
    armed_d = armed_q;
    if (!select_i) begin
      armed_d = 1'b1;
    end else if (hit) begin
      armed_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b1;
      xfer_q  <= 1'b0;
      ack_q   <= 1'b0;
      sel_q   <= REG_NONE;
      rnw_q   <= 1'b0;
      be3_q   <= 1'b0;
      wbits_q <= 2'b00;
    end else begin
      armed_q <= armed_d;
      xfer_q  <= hit;
      ack_q   <= xfer_q;
      if (hit) begin
        sel_q   <= decode_offset(32'(off));
        rnw_q   <= rnw_i;
        be3_q   <= be3_i;
        wbits_q <= wbits_i;
      end
    end
  end

  assign xfer_o  = xfer_q;
  assign sel_o   = sel_q;
  assign rnw_o   = rnw_q;
  assign be3_o   = be3_q;
  assign wbits_o = wbits_q;
  assign ack_o   = ack_q;

endmodule

// File: rtl/opb_register_simulink2ppc.sv
// Fabric-to-processor software register: captures user_data_in on user_valid and
// exposes DATA / STATUS / CTRL as a read-mostly OPB slave.
module opb_register_simulink2ppc
  import opb_register_simulink2ppc_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0100_0300,
  parameter logic [31:0] C_HIGHADDR   = 32'h0100_03FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter string       C_FAMILY     = "virtex5"
) (
  input  logic                        OPB_Clk,
  input  logic                        OPB_Rst_n,
  opb_register_simulink2ppc_if.slave  opb,
  input  logic [31:0]                 user_data_in,
  input  logic                        user_valid,
  output logic                        user_frozen
);

  logic       xfer;
  reg_sel_e   sel;
  logic       rnw;
  logic       be3;
  logic [1:0] wbits;
  logic       ack;

  opb_slave_decode #(
    .C_BASEADDR   (C_BASEADDR),
    .C_HIGHADDR   (C_HIGHADDR),
    .C_OPB_AWIDTH (C_OPB_AWIDTH)
  ) u_decode (
    .clk      (OPB_Clk),
    .rst_n    (OPB_Rst_n),
    .select_i (opb.OPB_select),
    .abus_i   (opb.OPB_ABus),
    .rnw_i    (opb.OPB_RNW),
    .be3_i    (opb.OPB_BE[3]),
    .wbits_i  (opb.OPB_DBus[30:31]),
    .xfer_o   (xfer),
    .sel_o    (sel),
    .rnw_o    (rnw),
    .be3_o    (be3),
    .wbits_o  (wbits),
    .ack_o    (ack)
  );

  logic [31:0]      data_q, data_d;
  logic             new_q, new_d;
  logic             ovr_q, ovr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             freeze_q, freeze_d;
  logic [C_OPB_DWIDTH-1:0] dbus_q, dbus_d;

  logic wr_ctrl, clr, data_rd, capture;
  logic [C_OPB_DWIDTH-1:0] rd_mux;

  assign wr_ctrl = xfer && !rnw && (sel == REG_CTRL) && be3;
  assign clr     = wr_ctrl && wbits[CTRL_CLR];
  assign data_rd = xfer && rnw && (sel == REG_DATA);
  assign capture = user_valid && !freeze_q;

  always_comb begin
    data_d   = data_q;
    new_d    = new_q;
    ovr_d    = ovr_q;
    cnt_d    = cnt_q;
    freeze_d = freeze_q;

    if (capture) begin
      data_d = user_data_in;
    end

    // A DATA read in the capture cycle still sees the old value, so no overrun.
    if (capture) begin
      new_d = 1'b1;
    end else if (data_rd) begin
      new_d = 1'b0;
    end

    if (clr) begin
      ovr_d = 1'b0;
      cnt_d = capture ? CNT_W'(1) : '0;
    end else if (capture) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (new_q && !data_rd) begin
        ovr_d = 1'b1;
      end
    end

    if (wr_ctrl) begin
      freeze_d = wbits[CTRL_FREEZE];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (sel)
      REG_DATA:   rd_mux = data_q;
      REG_STATUS: rd_mux = status_word(new_q, ovr_q, cnt_q);
      REG_CTRL:   rd_mux[CTRL_FREEZE] = freeze_q;
      default:    rd_mux = '0;
    endcase
    dbus_d = (xfer && rnw) ? rd_mux : '0;
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      data_q   <= '0;
      new_q    <= 1'b0;
      ovr_q    <= 1'b0;
      cnt_q    <= '0;
      freeze_q <= 1'b0;
      dbus_q   <= '0;
    end else begin
      data_q   <= data_d;
      new_q    <= new_d;
      ovr_q    <= ovr_d;
      cnt_q    <= cnt_d;
      freeze_q <= freeze_d;
      dbus_q   <= dbus_d;
    end
  end

  // Packed assignment maps value bit i onto Sl_DBus[31-i].
  assign opb.Sl_DBus    = dbus_q;
  assign opb.Sl_xferAck = ack;
  assign opb.Sl_errAck  = 1'b0;
  assign opb.Sl_retry   = 1'b0;
  assign opb.Sl_toutSup = 1'b0;
  assign user_frozen    = freeze_q;

endmodule

// File: tb/tb_opb_register_simulink2ppc.sv
// Self-checking bench: transaction-level register model plus a per-cycle monitor.
module tb_opb_register_simulink2ppc;

  localparam logic [31:0] BASE = 32'h0100_0300;
  localparam logic [31:0] HIGH = 32'h0100_03FF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] udata = '0;
  logic        uvalid = 1'b0;
  logic        ufrozen;

  opb_register_simulink2ppc_if bus();

  opb_register_simulink2ppc #(
    .C_BASEADDR (BASE),
    .C_HIGHADDR (HIGH)
  ) dut (
    .OPB_Clk      (clk),
    .OPB_Rst_n    (rst_n),
    .opb          (bus),
    .user_data_in (udata),
    .user_valid   (uvalid),
    .user_frozen  (ufrozen)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit running  = 1'b0;

  // Model state, described as the programmer sees the registers.
  logic [31:0] m_data;
  logic        m_new, m_ovr, m_freeze;
  logic [15:0] m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic model_reset();
    m_data = '0; m_new = 0; m_ovr = 0; m_freeze = 0; m_cnt = '0;
  endtask

  function automatic logic [31:0] model_value(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    if (addr < BASE || addr > HIGH) return 32'h0;
    case (off / 4)
      0: return m_data;
      1: return {m_cnt, 14'b0, m_ovr, m_new};
      2: return {31'b0, m_freeze};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_read(input logic [31:0] addr, output logic [31:0] v);
    v = model_value(addr);
    if (addr >= BASE && addr <= HIGH && (addr - BASE) / 4 == 0) m_new = 0;
  endtask

  task automatic model_capture(input logic [31:0] v, input bit allow_ovr);
    if (m_freeze) return;
    if (m_new && allow_ovr) m_ovr = 1;
    m_new  = 1;
    m_data = v;
    m_cnt  = m_cnt + 16'd1;
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [31:0] d,
                             input logic [0:3] be, output bit cleared);
    cleared = 0;
    if (addr == BASE + 32'h8 && be[3]) begin
      m_freeze = d[0];
      if (d[1]) begin
        m_ovr = 0; m_cnt = '0; cleared = 1;
      end
    end
  endtask

  task automatic capture(input logic [31:0] v);
    udata = v; uvalid = 1;
    @(posedge clk);
    model_capture(v, 1);
    @(negedge clk);
    uvalid = 0;
    $display("capture 0x%08h", v);
  endtask

  task automatic bus_read(input string name, input logic [31:0] addr, input logic [31:0] lit,
                          input bit collide, input logic [31:0] cval);
    logic [31:0] exp;
    int waited;
    bus.OPB_ABus = addr; bus.OPB_RNW = 1; bus.OPB_BE = 4'hF; bus.OPB_select = 1;
    @(posedge clk);
    @(negedge clk);
    check({name, "_ack_early"}, 32'(bus.Sl_xferAck), 32'h0);
    if (collide) begin udata = cval; uvalid = 1; end
    @(posedge clk);
    model_read(addr, exp);
    if (collide) model_capture(cval, 1);
    @(negedge clk);
    uvalid = 0;
    waited = 0;
    while (!bus.Sl_xferAck && waited < 6) begin @(negedge clk); waited++; end
    check({name, "_ack"}, 32'(bus.Sl_xferAck), 32'h1);
    check({name, "_model"}, bus.Sl_DBus, exp);
    check({name, "_lit"}, bus.Sl_DBus, lit);
    $display("read  %s addr 0x%08h data 0x%08h", name, addr, bus.Sl_DBus);
    bus.OPB_select = 0;
    @(negedge clk);
    check({name, "_ack_drop"}, 32'(bus.Sl_xferAck), 32'h0);
  endtask

  task automatic bus_write(input string name, input logic [31:0] addr, input logic [31:0] d,
                           input logic [0:3] be, input bit collide, input logic [31:0] cval);
    bit cleared;
    int waited;
    bus.OPB_ABus = addr; bus.OPB_RNW = 0; bus.OPB_BE = be; bus.OPB_DBus = d; bus.OPB_select = 1;
    @(posedge clk);
    @(negedge clk);
    if (collide) begin udata = cval; uvalid = 1; end
    @(posedge clk);
    model_write(addr, d, be, cleared);
    if (collide) model_capture(cval, !cleared);
    @(negedge clk);
    uvalid = 0;
    waited = 0;
    while (!bus.Sl_xferAck && waited < 6) begin @(negedge clk); waited++; end
    check({name, "_ack"}, 32'(bus.Sl_xferAck), 32'h1);
    check({name, "_wdbus"}, bus.Sl_DBus, 32'h0);
    $display("write %s addr 0x%08h data 0x%08h be %b", name, addr, d, be);
    bus.OPB_select = 0;
    @(negedge clk);
  endtask

  task automatic bus_probe(input string name, input logic [31:0] addr, input int cycles,
                           input int exp_acks);
    int acks;
    logic [31:0] dummy;
    acks = 0;
    bus.OPB_ABus = addr; bus.OPB_RNW = 1; bus.OPB_BE = 4'hF; bus.OPB_select = 1;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.Sl_xferAck) begin acks++; model_read(addr, dummy); end
    end
    bus.OPB_select = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.Sl_xferAck) begin acks++; model_read(addr, dummy); end
    end
    check({name, "_acks"}, 32'(acks), 32'(exp_acks));
    $display("probe %s addr 0x%08h acks %0d", name, addr, acks);
  endtask

  // Per-cycle monitor, sampled mid-high-phase so it never races the bench drivers.
  always @(posedge clk) begin
    if (running) begin
      #3;
      check("errAck", 32'(bus.Sl_errAck), 32'h0);
      check("retry", 32'(bus.Sl_retry), 32'h0);
      check("toutSup", 32'(bus.Sl_toutSup), 32'h0);
      check("frozen", 32'(ufrozen), 32'(m_freeze));
      if (!bus.Sl_xferAck) check("dbus_idle", bus.Sl_DBus, 32'h0);
      if (!rst_n) check("ack_in_reset", 32'(bus.Sl_xferAck), 32'h0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    model_reset();
    bus.OPB_ABus = BASE; bus.OPB_BE = 4'hF; bus.OPB_DBus = '0; bus.OPB_RNW = 1;
    bus.OPB_select = 1; bus.OPB_seqAddr = 0;
    uvalid = 1; udata = 32'h1234_5678;
    running = 1;

    repeat (4) begin
      @(negedge clk);
      check("rst_ack", 32'(bus.Sl_xferAck), 32'h0);
      check("rst_dbus", bus.Sl_DBus, 32'h0);
      check("rst_frozen", 32'(ufrozen), 32'h0);
    end
    bus.OPB_select = 0; uvalid = 0;
    @(negedge clk); rst_n = 1;
    @(negedge clk);

    bus_read("st_reset", BASE + 4, 32'h0000_0000, 0, 0);
    bus_read("dat_reset", BASE, 32'h0000_0000, 0, 0);

    capture(32'hDEAD_BEEF);
    bus_read("st_cap", BASE + 4, 32'h0001_0001, 0, 0);
    bus_read("dat_cap", BASE, 32'hDEAD_BEEF, 0, 0);
    bus_read("st_afterrd", BASE + 4, 32'h0001_0000, 0, 0);

    bus_write("clr0", BASE + 8, 32'h2, 4'hF, 0, 0);
    capture(32'h1);
    capture(32'h2);
    bus_read("st_ovr", BASE + 4, 32'h0002_0003, 0, 0);
    bus_write("clr1", BASE + 8, 32'h2, 4'hF, 0, 0);
    bus_read("st_clr", BASE + 4, 32'h0000_0001, 0, 0);
    bus_read("dat_ovr", BASE, 32'h0000_0002, 0, 0);
    bus_read("ctrl_clr_rd", BASE + 8, 32'h0000_0000, 0, 0);

    bus_write("frz", BASE + 8, 32'h1, 4'hF, 0, 0);
    check("frozen_set", 32'(ufrozen), 32'h1);
    capture(32'h55);
    bus_read("dat_frz", BASE, 32'h0000_0002, 0, 0);
    bus_read("st_frz", BASE + 4, 32'h0000_0000, 0, 0);
    bus_write("frz_be", BASE + 8, 32'h0, 4'b1110, 0, 0);
    check("frozen_be", 32'(ufrozen), 32'h1);
    bus_read("ctrl_frz", BASE + 8, 32'h0000_0001, 0, 0);
    bus_write("unfrz", BASE + 8, 32'h0, 4'hF, 0, 0);
    bus_read("ctrl_unfrz", BASE + 8, 32'h0000_0000, 0, 0);

    capture(32'h11);
    bus_read("dat_coll", BASE, 32'h0000_0011, 1, 32'hA5);
    bus_read("st_coll", BASE + 4, 32'h0002_0001, 0, 0);
    bus_read("dat_a5", BASE, 32'h0000_00A5, 0, 0);
    capture(32'h33);
    bus_write("clr_coll", BASE + 8, 32'h2, 4'hF, 1, 32'h77);
    bus_read("st_clrcoll", BASE + 4, 32'h0001_0001, 0, 0);
    bus_read("dat_77", BASE, 32'h0000_0077, 0, 0);

    bus_probe("above_win", HIGH + 4, 8, 0);
    bus_probe("below_win", BASE - 4, 8, 0);
    bus_probe("held_sel", BASE, 4, 1);
    bus_read("off_c", BASE + 32'hC, 32'h0, 0, 0);
    bus_read("off_10", BASE + 32'h10, 32'h0, 0, 0);
    bus_read("off_fc", BASE + 32'hFC, 32'h0, 0, 0);
    bus_write("wr_c", BASE + 32'hC, 32'hFFFF_FFFF, 4'hF, 0, 0);
    bus_read("ctrl_wr_c", BASE + 8, 32'h0, 0, 0);

    capture(32'h99);
    bus.OPB_ABus = BASE; bus.OPB_RNW = 1; bus.OPB_BE = 4'hF; bus.OPB_select = 1;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    model_read(BASE, rd);
    @(negedge clk);
    check("midrst_ack", 32'(bus.Sl_xferAck), 32'h1);
    check("midrst_dbus", bus.Sl_DBus, 32'h0000_0099);
    #1 rst_n = 0;
    model_reset();
    #1;
    check("midrst_ack_drop", 32'(bus.Sl_xferAck), 32'h0);
    check("midrst_dbus_drop", bus.Sl_DBus, 32'h0);
    $display("reset asserted mid-transfer");
    bus.OPB_select = 0;
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    bus_read("st_midrst", BASE + 4, 32'h0, 0, 0);
    bus_read("dat_midrst", BASE, 32'h0, 0, 0);

    running = 0;
    #20;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
